// File: rtl/counter_pkg.sv
// Shared types and widths for the counter_8 pulse generator.
package counter_pkg;

    localparam int unsigned CNT_W = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    // IDLE covers the first edge after reset (period load); RUN is free counting.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_e;

endpackage

// File: rtl/counter_8_dec_reload.sv
// Down-count arithmetic: decrement, or reload with load-1 at terminal count.
module dec_reload
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] next_count,
    output logic             tc
);

    // Terminal count at zero; load of 0 wraps to all-ones, giving a 2^WIDTH period.
    always_comb begin
        tc = (count == '0);
        if (tc) begin
            next_count = load - WIDTH'(1);
        end else begin
            next_count = count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_8.sv
// Programmable down-counting pulse generator: one-cycle tick every load clocks.
module counter_8
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pulse,
    input  logic [WIDTH-1:0] load
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] dec_next;
    logic             tc;
    logic             pulse_d;
    run_e             state;
    run_e             state_d;

    dec_reload #(
        .WIDTH(WIDTH)
    ) u_dec (
        .count      (count),
        .load       (load),
        .next_count (dec_next),
        .tc         (tc)
    );

    // Next state: first edge loads the period silently, then count down and tick at zero.
    always_comb begin
        state_d = state;
        count_d = count;
        pulse_d = 1'b0;
        case (state)
            ST_IDLE: begin
                count_d = load - WIDTH'(1);
                state_d = ST_RUN;
            end
            ST_RUN: begin
                count_d = dec_next;
                pulse_d = tc;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with asynchronous active-low reset; pulse is registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            count <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_d;
            count <= count_d;
            pulse <= pulse_d;
        end
    end

    a_pulse_in_reset : assert property (@(posedge clk) !rst |-> !pulse)
        else $error("pulse high during reset");

    a_reload_value : assert property (@(posedge clk) disable iff (!rst)
        (state == ST_IDLE || tc) |=> (count == ($past(load) - WIDTH'(1))))
        else $error("count not reloaded with load-1");

endmodule

// File: tb/tb_counter_8.sv
// Directed bench for counter_8: table of period scenarios plus hand sequences.
module tb_counter_8;

    logic       clk;
    logic       rst;
    logic       pulse;
    logic [7:0] load;

    int checks;
    int errors;

    logic p_log [0:1023];
    int   c_log [0:1023];

    typedef struct {
        logic [7:0] ld;
        int         ncyc;
        int         exp_first;
        int         exp_rises;
        int         exp_high;
        int         exp_cmax;
    } vec_t;

    vec_t vecs [6];

    counter_8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .pulse (pulse),
        .load  (load)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Must be called at a negedge; releases reset and logs pulse/count after each edge.
    task automatic observe(input int ncyc, input int chg_edge, input logic [7:0] chg_load);
        rst = 1'b1;
        for (int e = 1; e <= ncyc; e++) begin
            @(posedge clk);
            #1;
            p_log[e] = pulse;
            c_log[e] = int'(dut.count);
            if (e == chg_edge) load = chg_load;
        end
        @(negedge clk);
    endtask

    // Must be called at a negedge; holds reset for n edges checking cleared outputs.
    task automatic do_reset(input int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("reset_pulse", int'(pulse), 0);
            check("reset_count", int'(dut.count), 0);
        end
        @(negedge clk);
    endtask

    // Independent model of the logged run for a constant period L.
    task automatic analyze(input int ncyc, input int plen, input vec_t v);
        int first, rises, high, perr, cerr, cmax, exp_c, exp_p;
        logic prev;
        first = 0; rises = 0; high = 0; perr = 0; cerr = 0; cmax = 0;
        prev = 1'b0;
        for (int e = 1; e <= ncyc; e++) begin
            exp_c = (plen - 1) - ((e - 1) % plen);
            exp_p = (e >= 2 && ((e - 1) % plen) == 0) ? 1 : 0;
            if (int'(p_log[e]) != exp_p) perr++;
            if (c_log[e] != exp_c) cerr++;
            if (c_log[e] > cmax) cmax = c_log[e];
            if (p_log[e]) begin
                high++;
                if (!prev) begin
                    rises++;
                    if (first == 0) first = e;
                end
            end
            prev = p_log[e];
        end
        check("first_pulse_edge", first, v.exp_first);
        check("pulse_rises", rises, v.exp_rises);
        check("pulse_high_cycles", high, v.exp_high);
        check("count_max", cmax, v.exp_cmax);
        check("pulse_seq_errors", perr, 0);
        check("count_seq_errors", cerr, 0);
    endtask

    initial begin
        int rise_at [8];
        int nr;
        vec_t hv;
        checks = 0;
        errors = 0;

        vecs[0] = '{ld: 8'd10,  ncyc: 100, exp_first: 11,  exp_rises: 9,  exp_high: 9,  exp_cmax: 9};
        vecs[1] = '{ld: 8'd1,   ncyc: 20,  exp_first: 2,   exp_rises: 1,  exp_high: 19, exp_cmax: 0};
        vecs[2] = '{ld: 8'd0,   ncyc: 600, exp_first: 257, exp_rises: 2,  exp_high: 2,  exp_cmax: 255};
        vecs[3] = '{ld: 8'd255, ncyc: 600, exp_first: 256, exp_rises: 2,  exp_high: 2,  exp_cmax: 254};
        vecs[4] = '{ld: 8'd2,   ncyc: 21,  exp_first: 3,   exp_rises: 10, exp_high: 10, exp_cmax: 1};
        vecs[5] = '{ld: 8'd3,   ncyc: 30,  exp_first: 4,   exp_rises: 9,  exp_high: 9,  exp_cmax: 2};

        // Reset held from time zero for 6 cycles, checked after edges and mid-cycle.
        rst  = 1'b0;
        load = 8'd10;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_pulse", int'(pulse), 0);
            check("rst_hold_count", int'(dut.count), 0);
            #4;
            check("rst_mid_pulse", int'(pulse), 0);
        end
        @(negedge clk);

        // Table-driven period scenarios.
        for (int i = 0; i < 6; i++) begin
            do_reset(2);
            load = vecs[i].ld;
            observe(vecs[i].ncyc, 0, 8'd0);
            analyze(vecs[i].ncyc, (vecs[i].ld == 8'd0) ? 256 : int'(vecs[i].ld), vecs[i]);
        end

        // Mid-period load change 10 -> 4: current period ends at edge 11, then every 4.
        do_reset(2);
        load = 8'd10;
        observe(30, 5, 8'd4);
        check("chg_count_at_edge5", c_log[5], 5);
        nr = 0;
        for (int e = 1; e <= 30; e++) begin
            if (p_log[e] && !p_log[e-1 < 1 ? 1 : e-1] || (e == 1 && p_log[e])) begin
                if (nr < 8) rise_at[nr] = e;
                nr++;
            end
        end
        check("chg_rises", nr, 5);
        check("chg_rise0", rise_at[0], 11);
        check("chg_rise1", rise_at[1], 15);
        check("chg_rise2", rise_at[2], 19);
        check("chg_rise4", rise_at[4], 27);

        // Reset asserted mid-cycle while count=5 clears count and state at once.
        do_reset(2);
        load = 8'd10;
        observe(5, 0, 8'd0);
        check("pre_rst_count", int'(dut.count), 5);
        #2;
        rst = 1'b0;
        #1;
        check("async_count_clear", int'(dut.count), 0);
        check("async_state_clear", int'(dut.state), 0);
        check("async_pulse_low", int'(pulse), 0);

        // Reset asserted mid-cycle while pulse is high drops it without a clock edge.
        @(negedge clk);
        load = 8'd1;
        observe(4, 0, 8'd0);
        check("pre_rst_pulse", int'(pulse), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_pulse_drop", int'(pulse), 0);

        // Restart after mid-period reset: first pulse again at edge load+1.
        @(negedge clk);
        load = 8'd10;
        observe(25, 0, 8'd0);
        hv = '{ld: 8'd10, ncyc: 25, exp_first: 11, exp_rises: 2, exp_high: 2, exp_cmax: 9};
        analyze(25, 10, hv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
